// File: rtl/regbank_if.sv
// Serial-link side of the register bank: address/byte strobes from the
// serial slave and the read data returned to it.
interface regbank_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              addr_dv;
  logic              rw_out;
  logic              rxdv;
  logic [DATA_W-1:0] rx_d;
  logic              xfer_end;
  logic [DATA_W-1:0] tx_d;

  modport master (
    output addr, addr_dv, rw_out, rxdv, rx_d, xfer_end,
    input  tx_d
  );

  modport slave (
    input  addr, addr_dv, rw_out, rxdv, rx_d, xfer_end,
    output tx_d
  );
endinterface

// File: rtl/regbank_wrap.sv
// Register bank behind a byte-serial slave: decodes the transaction address
// into a channel pointer, streams write bytes into data_out lanes and read
// bytes out of data_in lanes, with optional pointer auto-increment.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transaction; byte strobes ignored
// S_WR   | write burst; each rxdv writes rx_d to lane ptr
// S_RD   | read burst; each rxdv advances ptr and reads the new lane
// S_BAD  | address out of range; bytes swallowed, tx_d forced to 0
module regbank_wrap #(
  parameter int              NUM_REGS  = 4,
  parameter int              DATA_W    = 8,
  parameter int              ADDR_W    = 7,
  parameter int              BASE_ADDR = 0,
  parameter int              AUTO_INC  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  regbank_if.slave                     bus,
  input  logic [NUM_REGS*DATA_W-1:0]   data_in,
  input  logic                         err_clr,
  output logic [NUM_REGS*DATA_W-1:0]   data_out,
  output logic [NUM_REGS-1:0]          wr_en,
  output logic [NUM_REGS-1:0]          rd_en,
  output logic                         err
);

  localparam int                PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int                AW1   = ADDR_W + 1;
  localparam logic [AW1-1:0]    BASE  = AW1'(BASE_ADDR);
  localparam logic [AW1-1:0]    NREG  = AW1'(NUM_REGS);
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_BAD} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt, acc_ptr, rd_ptr;
  logic               rd_pend;
  logic [DATA_W-1:0]  tx_q;
  logic [AW1-1:0]     diff;
  logic [ADDR_W-1:0]  idx;
  logic               in_range;
  logic               wr_fire, rd_fire, tx_zero, bad_dec;

  function automatic logic [PTR_W-1:0] ptr_step(input logic [PTR_W-1:0] p);
    if (AUTO_INC == 0) return p;
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Address decode: the borrow bit of the extended subtraction flags addr < BASE_ADDR.
  always_comb begin
    diff     = {1'b0, bus.addr} - BASE;
    idx      = diff[ADDR_W-1:0];
    in_range = !diff[ADDR_W] && ({1'b0, idx} < NREG);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state: a new address always wins over end-of-transaction.
  always_comb begin
    state_nxt = state;
    if (bus.addr_dv) begin
      if (!in_range)       state_nxt = S_BAD;
      else if (bus.rw_out) state_nxt = S_RD;
      else                 state_nxt = S_WR;
    end else if (bus.xfer_end) begin
      state_nxt = S_IDLE;
    end
  end

  // Output decode: which lane is accessed this cycle and where the pointer goes next.
  always_comb begin
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    tx_zero = 1'b0;
    bad_dec = 1'b0;
    acc_ptr = ptr;
    ptr_nxt = ptr;
    if (bus.addr_dv) begin
      if (!in_range) begin
        bad_dec = 1'b1;
        tx_zero = 1'b1;
      end else begin
        acc_ptr = idx[PTR_W-1:0];
        ptr_nxt = idx[PTR_W-1:0];
        if (bus.rw_out) begin
          rd_fire = 1'b1;
        end else if (bus.rxdv) begin
          wr_fire = 1'b1;
          ptr_nxt = ptr_step(idx[PTR_W-1:0]);
        end
      end
    end else if (bus.rxdv) begin
      case (state)
        S_WR: begin
          wr_fire = 1'b1;
          ptr_nxt = ptr_step(ptr);
        end
        S_RD: begin
          rd_fire = 1'b1;
          acc_ptr = ptr_step(ptr);
          ptr_nxt = ptr_step(ptr);
        end
        S_BAD:   tx_zero = 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: pointer, lane writes, one-cycle strobes, read-data pipeline, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      data_out <= {NUM_REGS{RST_VAL}};
      wr_en    <= '0;
      rd_en    <= '0;
      rd_pend  <= 1'b0;
      rd_ptr   <= '0;
      tx_q     <= '0;
      err      <= 1'b0;
    end else begin
      ptr     <= ptr_nxt;
      wr_en   <= '0;
      rd_en   <= '0;
      rd_pend <= rd_fire;
      rd_ptr  <= acc_ptr;
      if (wr_fire) begin
        wr_en[acc_ptr]                     <= 1'b1;
        data_out[acc_ptr*DATA_W +: DATA_W] <= bus.rx_d;
      end
      if (rd_fire) rd_en[acc_ptr] <= 1'b1;
      if (tx_zero)      tx_q <= '0;
      else if (rd_pend) tx_q <= data_in[rd_ptr*DATA_W +: DATA_W];
      if (bad_dec)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign bus.tx_d = tx_q;

endmodule

// File: tb/tb_regbank_wrap.sv
// Bench for regbank_wrap: directed scenarios plus a randomized transaction
// stream checked against a lane-array model of the register bank.
module tb_regbank_wrap;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regbank_if #(.ADDR_W(7), .DATA_W(8)) bus  ();
  regbank_if #(.ADDR_W(7), .DATA_W(8)) bus2 ();

  logic [31:0] din, din2, dout, dout2;
  logic [3:0]  wr_en, rd_en, wr_en2, rd_en2;
  logic        err_clr, err_clr2, err, err2;

  int total = 0;
  int bad   = 0;

  regbank_wrap #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(7), .BASE_ADDR(0),
                 .AUTO_INC(1), .RST_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .bus(bus), .data_in(din), .err_clr(err_clr),
    .data_out(dout), .wr_en(wr_en), .rd_en(rd_en), .err(err));

  regbank_wrap #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(7), .BASE_ADDR(0),
                 .AUTO_INC(0), .RST_VAL(8'h00)) dut_ni (
    .clk(clk), .reset(reset), .bus(bus2), .data_in(din2), .err_clr(err_clr2),
    .data_out(dout2), .wr_en(wr_en2), .rd_en(rd_en2), .err(err2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw);
    bus.addr = a; bus.rw_out = rw; bus.addr_dv = 1'b1;
    tick();
    bus.addr_dv = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.rx_d = d; bus.rxdv = 1'b1;
    tick();
    bus.rxdv = 1'b0;
  endtask

  task automatic end_xfer();
    bus.xfer_end = 1'b1; err_clr = 1'b1;
    tick();
    bus.xfer_end = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL rst_data_out got=%h exp=%h", dout, 32'h0); end
    total++; if ({wr_en, rd_en} !== 8'h0) begin bad++; $display("FAIL rst_strobes got=%b exp=%b", {wr_en, rd_en}, 8'h0); end
    total++; if (bus.tx_d !== 8'h0) begin bad++; $display("FAIL rst_tx_d got=%h exp=%h", bus.tx_d, 8'h0); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (dout2 !== 32'h0) begin bad++; $display("FAIL rst_data_out_ni got=%h exp=%h", dout2, 32'h0); end
  endtask

  task automatic test_write_burst();
    logic [7:0] wd [3];
    logic [3:0] we [3];
    wd = '{8'hA5, 8'h3C, 8'h7E};
    we = '{4'b0010, 4'b0100, 4'b1000};
    send_addr(7'd1, 1'b0);
    total++; if ({wr_en, rd_en} !== 8'h0) begin bad++; $display("FAIL wb_addr_strobe got=%b exp=%b", {wr_en, rd_en}, 8'h0); end
    for (int i = 0; i < 3; i++) begin
      send_byte(wd[i]);
      total++; if (wr_en !== we[i]) begin bad++; $display("FAIL wb_wr_en[%0d] got=%b exp=%b", i, wr_en, we[i]); end
      total++; if (rd_en !== 4'b0) begin bad++; $display("FAIL wb_rd_en[%0d] got=%b exp=0000", i, rd_en); end
      total++; if (dout[(i+1)*8 +: 8] !== wd[i]) begin bad++; $display("FAIL wb_lane[%0d] got=%h exp=%h", i+1, dout[(i+1)*8 +: 8], wd[i]); end
    end
    total++; if (dout !== 32'h7E3CA500) begin bad++; $display("FAIL wb_data_out got=%h exp=%h", dout, 32'h7E3CA500); end
    end_xfer();
  endtask

  task automatic test_read_wrap();
    logic [3:0] re [2];
    logic [7:0] rt [2];
    re = '{4'b0001, 4'b0010};
    rt = '{8'h11, 8'h22};
    din = 32'h44332211;
    send_addr(7'd3, 1'b1);
    total++; if ({wr_en, rd_en} !== 8'b0000_1000) begin bad++; $display("FAIL rd_first_strobe got=%b exp=%b", {wr_en, rd_en}, 8'b0000_1000); end
    tick();
    total++; if (bus.tx_d !== 8'h44) begin bad++; $display("FAIL rd_first_tx got=%h exp=44", bus.tx_d); end
    total++; if (rd_en !== 4'b0) begin bad++; $display("FAIL rd_single_cycle got=%b exp=0000", rd_en); end
    for (int i = 0; i < 2; i++) begin
      send_byte(8'h00);
      total++; if ({wr_en, rd_en} !== {4'b0, re[i]}) begin bad++; $display("FAIL rd_strobe[%0d] got=%b exp=%b", i, {wr_en, rd_en}, {4'b0, re[i]}); end
      tick();
      total++; if (bus.tx_d !== rt[i]) begin bad++; $display("FAIL rd_tx[%0d] got=%h exp=%h", i, bus.tx_d, rt[i]); end
    end
    end_xfer();
    tick();
    total++; if (bus.tx_d !== 8'h22) begin bad++; $display("FAIL rd_tx_hold got=%h exp=22", bus.tx_d); end
  endtask

  task automatic test_idle_ignore();
    send_byte(8'hFF);
    total++; if ({wr_en, rd_en} !== 8'h0) begin bad++; $display("FAIL idle_strobe got=%b exp=%b", {wr_en, rd_en}, 8'h0); end
    total++; if (dout !== 32'h7E3CA500) begin bad++; $display("FAIL idle_data_out got=%h exp=%h", dout, 32'h7E3CA500); end
  endtask

  task automatic test_out_of_range();
    send_addr(7'h75, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_err_set got=%b exp=1", err); end
    total++; if (bus.tx_d !== 8'h0) begin bad++; $display("FAIL oor_tx_zero got=%h exp=00", bus.tx_d); end
    send_byte(8'h55);
    total++; if ({wr_en, rd_en} !== 8'h0) begin bad++; $display("FAIL oor_strobe got=%b exp=%b", {wr_en, rd_en}, 8'h0); end
    total++; if (dout !== 32'h7E3CA500) begin bad++; $display("FAIL oor_data_out got=%h exp=%h", dout, 32'h7E3CA500); end
    total++; if (bus.tx_d !== 8'h0) begin bad++; $display("FAIL oor_byte_tx got=%h exp=00", bus.tx_d); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL oor_err_clr got=%b exp=0", err); end
    err_clr = 1'b1;
    send_addr(7'h75, 1'b1);
    err_clr = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_set_beats_clr got=%b exp=1", err); end
    tick();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_err_sticky got=%b exp=1", err); end
    end_xfer();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL oor_err_final got=%b exp=0", err); end
  endtask

  task automatic test_coincident();
    bus.addr = 7'd2; bus.rw_out = 1'b0; bus.rx_d = 8'h5A;
    bus.addr_dv = 1'b1; bus.rxdv = 1'b1;
    tick();
    bus.addr_dv = 1'b0; bus.rxdv = 1'b0;
    total++; if (dout[23:16] !== 8'h5A) begin bad++; $display("FAIL coin_lane2 got=%h exp=5A", dout[23:16]); end
    total++; if (wr_en !== 4'b0100) begin bad++; $display("FAIL coin_wr_en got=%b exp=0100", wr_en); end
    send_byte(8'hC3);
    total++; if (wr_en !== 4'b1000) begin bad++; $display("FAIL coin_next_wr_en got=%b exp=1000", wr_en); end
    total++; if (dout !== 32'hC35AA500) begin bad++; $display("FAIL coin_data_out got=%h exp=%h", dout, 32'hC35AA500); end
    end_xfer();
  endtask

  task automatic test_mid_reset();
    din = 32'h44332211;
    send_addr(7'h75, 1'b0);
    send_addr(7'd1, 1'b1);
    tick();
    total++; if (bus.tx_d !== 8'h22) begin bad++; $display("FAIL mr_pre_tx got=%h exp=22", bus.tx_d); end
    send_addr(7'd0, 1'b0);
    send_byte(8'h11);
    total++; if (wr_en !== 4'b0001) begin bad++; $display("FAIL mr_pre_wr_en got=%b exp=0001", wr_en); end
    bus.rx_d = 8'h22; bus.rxdv = 1'b1; reset = 1'b1;
    tick();
    bus.rxdv = 1'b0; reset = 1'b0;
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL mr_data_out got=%h exp=%h", dout, 32'h0); end
    total++; if ({wr_en, rd_en} !== 8'h0) begin bad++; $display("FAIL mr_strobes got=%b exp=%b", {wr_en, rd_en}, 8'h0); end
    total++; if (bus.tx_d !== 8'h0) begin bad++; $display("FAIL mr_tx_d got=%h exp=00", bus.tx_d); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mr_err got=%b exp=0", err); end
    send_byte(8'h33);
    total++; if ({wr_en, rd_en} !== 8'h0) begin bad++; $display("FAIL mr_post_strobe got=%b exp=%b", {wr_en, rd_en}, 8'h0); end
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL mr_post_data_out got=%h exp=%h", dout, 32'h0); end
  endtask

  task automatic test_no_inc();
    logic [7:0] wd [3];
    wd = '{8'h10, 8'h20, 8'h30};
    bus2.addr = 7'd0; bus2.rw_out = 1'b0; bus2.addr_dv = 1'b1;
    tick();
    bus2.addr_dv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus2.rx_d = wd[i]; bus2.rxdv = 1'b1;
      tick();
      bus2.rxdv = 1'b0;
      total++; if (wr_en2 !== 4'b0001) begin bad++; $display("FAIL ni_wr_en[%0d] got=%b exp=0001", i, wr_en2); end
      total++; if (dout2[7:0] !== wd[i]) begin bad++; $display("FAIL ni_lane0[%0d] got=%h exp=%h", i, dout2[7:0], wd[i]); end
    end
    total++; if (dout2 !== 32'h00000030) begin bad++; $display("FAIL ni_data_out got=%h exp=%h", dout2, 32'h30); end
    din2 = 32'hDDCCBBAA;
    bus2.addr = 7'd2; bus2.rw_out = 1'b1; bus2.addr_dv = 1'b1;
    tick();
    bus2.addr_dv = 1'b0;
    total++; if (rd_en2 !== 4'b0100) begin bad++; $display("FAIL ni_rd_en got=%b exp=0100", rd_en2); end
    tick();
    total++; if (bus2.tx_d !== 8'hCC) begin bad++; $display("FAIL ni_tx got=%h exp=CC", bus2.tx_d); end
    din2 = 32'hDD77BBAA;
    bus2.rxdv = 1'b1;
    tick();
    bus2.rxdv = 1'b0;
    total++; if (rd_en2 !== 4'b0100) begin bad++; $display("FAIL ni_reread_rd_en got=%b exp=0100", rd_en2); end
    tick();
    total++; if (bus2.tx_d !== 8'h77) begin bad++; $display("FAIL ni_reread_tx got=%h exp=77", bus2.tx_d); end
    bus2.xfer_end = 1'b1; tick(); bus2.xfer_end = 1'b0;
  endtask

  // Randomized transactions against a lane array: writes land at (start+k) mod 4,
  // reads return data_in at (start+k) mod 4, out-of-range addresses touch nothing.
  task automatic test_random();
    logic [7:0]  mem [4];
    logic [7:0]  last_tx;
    logic [31:0] exp_vec;
    logic [7:0]  d;
    int a, rw, n, p;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    last_tx = 8'h00;
    for (int t = 0; t < 60; t++) begin
      a  = $urandom_range(0, 7);
      rw = $urandom_range(0, 1);
      n  = $urandom_range(0, 5);
      din = $urandom;
      send_addr(7'(a), rw[0]);
      if (a >= 4) begin
        last_tx = 8'h00;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL rnd_err t=%0d got=%b exp=1", t, err); end
        for (int k = 0; k < n; k++) begin
          send_byte(8'($urandom));
          total++; if ({wr_en, rd_en, bus.tx_d} !== 16'h0) begin bad++; $display("FAIL rnd_bad_byte t=%0d got=%h exp=0000", t, {wr_en, rd_en, bus.tx_d}); end
        end
      end else if (rw == 1) begin
        p = a;
        total++; if ({wr_en, rd_en} !== {4'b0, 4'(1 << p)}) begin bad++; $display("FAIL rnd_rd_en t=%0d got=%b exp=%b", t, {wr_en, rd_en}, {4'b0, 4'(1 << p)}); end
        tick();
        last_tx = din[p*8 +: 8];
        total++; if (bus.tx_d !== last_tx) begin bad++; $display("FAIL rnd_rd_tx t=%0d got=%h exp=%h", t, bus.tx_d, last_tx); end
        for (int k = 0; k < n; k++) begin
          p = (p + 1) % 4;
          send_byte(8'($urandom));
          total++; if ({wr_en, rd_en} !== {4'b0, 4'(1 << p)}) begin bad++; $display("FAIL rnd_rd_en t=%0d k=%0d got=%b exp=%b", t, k, {wr_en, rd_en}, {4'b0, 4'(1 << p)}); end
          tick();
          last_tx = din[p*8 +: 8];
          total++; if (bus.tx_d !== last_tx) begin bad++; $display("FAIL rnd_rd_tx t=%0d k=%0d got=%h exp=%h", t, k, bus.tx_d, last_tx); end
        end
      end else begin
        p = a;
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          send_byte(d);
          mem[p] = d;
          total++; if ({wr_en, rd_en} !== {4'(1 << p), 4'b0}) begin bad++; $display("FAIL rnd_wr_en t=%0d k=%0d got=%b exp=%b", t, k, {wr_en, rd_en}, {4'(1 << p), 4'b0}); end
          p = (p + 1) % 4;
        end
      end
      end_xfer();
      for (int i = 0; i < 4; i++) exp_vec[i*8 +: 8] = mem[i];
      total++; if (dout !== exp_vec) begin bad++; $display("FAIL rnd_data_out t=%0d got=%h exp=%h", t, dout, exp_vec); end
      total++; if (bus.tx_d !== last_tx) begin bad++; $display("FAIL rnd_tx_hold t=%0d got=%h exp=%h", t, bus.tx_d, last_tx); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rnd_err_clr t=%0d got=%b exp=0", t, err); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.addr = '0;  bus.addr_dv = 1'b0;  bus.rw_out = 1'b0;  bus.rxdv = 1'b0;  bus.rx_d = '0;  bus.xfer_end = 1'b0;
    bus2.addr = '0; bus2.addr_dv = 1'b0; bus2.rw_out = 1'b0; bus2.rxdv = 1'b0; bus2.rx_d = '0; bus2.xfer_end = 1'b0;
    din = '0; din2 = '0; err_clr = 1'b0; err_clr2 = 1'b0;
    test_reset();
    test_write_burst();
    test_read_wrap();
    test_idle_ignore();
    test_out_of_range();
    test_coincident();
    test_mid_reset();
    test_no_inc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regbank_wrap.md
REGBANK_WRAP -- requirements
Module: regbank_wrap

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4, number of mapped registers/channels (1..64).
REQ-002 The block SHALL have parameter DATA_W, default 8, register and byte-lane width.
REQ-003 The block SHALL have parameter ADDR_W, default 7, width of the serial-link address.
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, address of register 0.
REQ-005 The block SHALL have parameter AUTO_INC, default 1, where 1 enables pointer auto-increment on burst bytes.
REQ-006 The block SHALL have parameter RST_VAL, default 0, reset value of every data_out register.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port addr, input, ADDR_W bits: transaction address from the serial slave.
REQ-010 The block SHALL have port addr_dv, input, 1 bit: one-cycle strobe marking addr and rw_out valid.
REQ-011 The block SHALL have port rw_out, input, 1 bit: 1 = read transaction, 0 = write.
REQ-012 The block SHALL have port rxdv, input, 1 bit: one-cycle strobe per completed byte on the link.
REQ-013 The block SHALL have port rx_d, input, DATA_W bits: received write data, valid with rxdv.
REQ-014 The block SHALL have port xfer_end, input, 1 bit: one-cycle strobe marking end of transaction.
REQ-015 The block SHALL have port data_in, input, NUM_REGS*DATA_W bits: read-back data, channel i at bits [i*DATA_W +: DATA_W].
REQ-016 The block SHALL have port err_clr, input, 1 bit: clears err.
REQ-017 The block SHALL have port data_out, output, NUM_REGS*DATA_W bits: written register contents, same packing as data_in.
REQ-018 The block SHALL have port wr_en, output, NUM_REGS bits: one-hot, one-cycle write strobe per channel.
REQ-019 The block SHALL have port rd_en, output, NUM_REGS bits: one-hot, one-cycle read strobe per channel.
REQ-020 The block SHALL have port tx_d, output, DATA_W bits: read data returned to the serial slave.
REQ-021 The block SHALL have port err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-022 The FSM SHALL have states IDLE, WR, RD and BAD, and SHALL move from any state to WR, RD or BAD on addr_dv according to rw_out and the decode result.
REQ-023 Decode SHALL be idx = addr - BASE_ADDR (ADDR_W-bit unsigned); an access SHALL be in range iff addr >= BASE_ADDR and idx < NUM_REGS.
REQ-024 On addr_dv in range, the block SHALL load pointer ptr <= idx; out of range, it SHALL enter BAD and set err the next cycle.
REQ-025 In WR, each rxdv SHALL write rx_d to data_out[ptr] and assert wr_en[ptr] exactly one cycle, both visible at N+1 for a strobe at cycle N.
REQ-026 In RD, entry at cycle N SHALL assert rd_en[ptr] at N+1 and register data_in[ptr] onto tx_d at N+2.
REQ-027 In RD, each rxdv SHALL advance ptr (if AUTO_INC) and repeat the REQ-026 timing for the new ptr; with AUTO_INC=0 it SHALL re-read the same ptr.
REQ-028 In WR with AUTO_INC=1, ptr SHALL increment after each write; with AUTO_INC=0, ptr SHALL hold.
REQ-029 Pointer increment SHALL wrap from NUM_REGS-1 to 0.
REQ-030 If addr_dv and rxdv coincide with rw_out=0 and the address in range, the block SHALL write rx_d to the newly decoded idx and leave ptr at idx+1 (AUTO_INC=1).
REQ-031 In BAD, rxdv SHALL produce no wr_en or rd_en, SHALL leave data_out unchanged, and SHALL drive tx_d to 0.
REQ-032 xfer_end SHALL return the FSM to IDLE next cycle; addr_dv in the same cycle SHALL take priority over xfer_end.
REQ-033 In IDLE, rxdv SHALL be ignored.
REQ-034 The block SHALL never assert more than one bit of wr_en or rd_en, and SHALL never assert wr_en and rd_en in the same cycle.
REQ-035 err SHALL stay set until err_clr; err_clr and a new out-of-range addr_dv in the same cycle SHALL leave err = 1.
REQ-036 tx_d SHALL hold its last value when no read is in progress.

Reset
REQ-037 When reset is high at a clk edge, the block SHALL go to IDLE and set ptr = 0, every data_out lane = RST_VAL, wr_en = 0, rd_en = 0, tx_d = 0, err = 0, overriding any simultaneous strobe.
REQ-038 Reset asserted mid-burst SHALL discard the transaction; after release, the block SHALL produce no strobes until the next addr_dv.

Verification
REQ-039 Write burst test: defaults, addr_dv with addr=1, rw_out=0, then rxdv x3 with rx_d A5, 3C, 7E -> wr_en 0010, 0100, 1000; data_out lanes 1..3 = A5, 3C, 7E.
REQ-040 Read wrap test: data_in lanes = 11, 22, 33, 44; addr_dv with addr=3, rw_out=1, then rxdv x2 -> rd_en 1000, 0001, 0010; tx_d 44, 11, 22 at N+2 of each.
REQ-041 Out-of-range test: addr=75h, BASE_ADDR=0 -> err=1, no strobes, tx_d=0; err_clr -> err=0.
REQ-042 Coincident strobe test: addr_dv and rxdv in the same cycle, addr=2, rx_d=5A -> data_out lane 2 = 5A at N+1.
REQ-043 Mid-burst reset test: reset mid-burst -> all outputs at reset values; later rxdv without addr_dv -> no wr_en.
REQ-044 AUTO_INC=0 test: three writes to addr=0 -> lane 0 holds the last byte; lanes 1..3 remain RST_VAL.
